// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed 7-segment driver: double-dabble binary-to-BCD conversion
// feeding a free-running scan of active-low anodes with optional leading-zero blanking.
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  digit,
    output logic [3:0]  anode,
    output logic        dbg_state
);

    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Handshake: load is a one-cycle request, taken only when sampled with busy=0;
    // busy stays high from the capture edge until the commit edge, inclusive of neither.
    state_t         state_q;
    logic           busy_q;
    logic           ovf_q;
    logic           ovf_cap_q;
    logic [13:0]    shift_q, shift_d;
    logic [15:0]    bcd_q, bcd_d, bcd_adj;
    logic [3:0]     step_q;
    logic [15:0]    disp_q;

    logic [PW-1:0]  presc_q;
    logic [1:0]     scan_q;
    logic [3:0]     anode_q, an_d;
    logic [3:0]     digit_q, dig_d;
    logic [3:0]     blank;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d   = {bcd_adj[14:0], shift_q[13]};
        shift_d = {shift_q[12:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cap_q <= 1'b0;
            shift_q   <= '0;
            bcd_q     <= '0;
            step_q    <= '0;
            disp_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shift_q   <= value;
                        bcd_q     <= '0;
                        step_q    <= '0;
                        ovf_cap_q <= (value > 14'd9999);
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_d;
                    bcd_q   <= bcd_d;
                    step_q  <= step_q + 4'd1;
                    // Last of the 14 steps: commit the whole display in one edge.
                    if (step_q == 4'd13) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ovf_q   <= ovf_cap_q;
                        disp_q  <= ovf_cap_q ? 16'hFFFF : bcd_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        blank = 4'b0000;
        if (BLANK_LZ && !ovf_q) begin
            blank[3] = (disp_q[15:12] == 4'd0);
            blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
            blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
        end
        an_d  = ~(4'b0001 << scan_q) | {4{blank[scan_q]}};
        dig_d = disp_q[4*scan_q +: 4];
    end

    // Scan runs independently of the converter; outputs lag the index by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            scan_q  <= '0;
            anode_q <= 4'b1110;
            digit_q <= 4'h0;
        end else begin
            if (presc_q == PW'(REFRESH_DIV - 1)) begin
                presc_q <= '0;
                scan_q  <= scan_q + 2'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            anode_q <= an_d;
            digit_q <= dig_d;
        end
    end

    assign busy      = busy_q;
    assign overflow  = ovf_q;
    assign anode     = anode_q;
    assign digit     = digit_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with REFRESH_DIV=4: conversions, blanking,
// overflow, load-while-busy, load on the commit edge and reset mid-conversion.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        dbg_state;

    int total = 0;
    int bad   = 0;
    int ncyc;

    ssd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .load      (load),
        .busy      (busy),
        .overflow  (overflow),
        .digit     (digit),
        .anode     (anode),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a conversion; optionally pulse a second load before edge late_edge.
    task automatic run_conv(input logic [13:0] v, input int late_edge,
                            input logic [13:0] v2, output int n);
        @(negedge clk); value = v; load = 1'b1;
        @(negedge clk); load = 1'b0;
        n = 0;
        for (int k = 1; k <= 40 && busy; k++) begin
            n++;
            if (k == late_edge) begin
                load  = 1'b1;
                value = v2;
            end
            @(negedge clk); load = 1'b0;
        end
    endtask

    // Align to the first cycle of position 0, then check one full 16-cycle scan.
    task automatic check_scan(input string tag, input logic [15:0] digs, input logic [3:0] blank);
        logic [3:0] prev;
        logic [3:0] exp_an;
        bit found = 0;
        prev = anode;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (anode == 4'b1110 && prev != 4'b1110) found = 1;
            else prev = anode;
        end
        chk({tag, "_sync"}, {15'd0, found}, 16'd1);
        for (int i = 0; i < 16; i++) begin
            int p;
            p = i / 4;
            exp_an = blank[p] ? 4'b1111 : ~(4'b0001 << p);
            chk($sformatf("%s_an%0d", tag, i), {12'd0, anode}, {12'd0, exp_an});
            chk($sformatf("%s_dg%0d", tag, i), {12'd0, digit}, {12'd0, digs[4*p +: 4]});
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; value = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ovf", {15'd0, overflow}, 16'd0);
        chk("rst_anode", {12'd0, anode}, 16'h000E);
        chk("rst_digit", {12'd0, digit}, 16'h0000);
        chk("rst_state", {15'd0, dbg_state}, 16'd0);

        // 1234, with a load landing on the commit edge that must be ignored.
        run_conv(14'd1234, 14, 14'd8888, ncyc);
        chk("c1234_busy_cycles", 16'(ncyc), 16'd14);
        @(negedge clk);
        chk("c1234_no_restart", {15'd0, busy}, 16'd0);
        chk("c1234_ovf", {15'd0, overflow}, 16'd0);
        check_scan("c1234", 16'h1234, 4'b0000);

        run_conv(14'd7, 0, 14'd0, ncyc);
        chk("c7_busy_cycles", 16'(ncyc), 16'd14);
        check_scan("c7", 16'h0007, 4'b1110);

        run_conv(14'd10000, 0, 14'd0, ncyc);
        chk("c10000_busy_cycles", 16'(ncyc), 16'd14);
        chk("c10000_ovf", {15'd0, overflow}, 16'd1);
        check_scan("c10000", 16'hFFFF, 4'b0000);

        // Second load at E5 is dropped; overflow clears on this commit.
        run_conv(14'd42, 5, 14'd99, ncyc);
        chk("c42_busy_cycles", 16'(ncyc), 16'd14);
        chk("c42_ovf", {15'd0, overflow}, 16'd0);
        repeat (3) @(negedge clk);
        chk("c42_no_second", {15'd0, busy}, 16'd0);
        check_scan("c42", 16'h0042, 4'b1100);

        // Reset at E7 of a 5555 conversion, together with a load.
        @(negedge clk); value = 14'd5555; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy_before", {15'd0, busy}, 16'd1);
        reset = 1'b1; load = 1'b1; value = 14'd1111;
        @(negedge clk);
        reset = 1'b0; load = 1'b0;
        chk("mid_busy", {15'd0, busy}, 16'd0);
        chk("mid_state", {15'd0, dbg_state}, 16'd0);
        chk("mid_anode", {12'd0, anode}, 16'h000E);
        chk("mid_digit", {12'd0, digit}, 16'h0000);
        @(negedge clk);
        chk("mid_busy_after", {15'd0, busy}, 16'd0);
        check_scan("mid_clear", 16'h0000, 4'b1110);

        run_conv(14'd9999, 0, 14'd0, ncyc);
        chk("c9999_busy_cycles", 16'(ncyc), 16'd14);
        chk("c9999_ovf", {15'd0, overflow}, 16'd0);
        check_scan("c9999", 16'h9999, 4'b0000);

        run_conv(14'd0, 0, 14'd0, ncyc);
        chk("c0_busy_cycles", 16'(ncyc), 16'd14);
        check_scan("c0", 16'h0000, 4'b1110);

        run_conv(14'd305, 0, 14'd0, ncyc);
        check_scan("c305", 16'h0305, 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
